if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 192 +++++++++++++++++++
 tb/tb_if_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a credit-controlled fetch queue.
//
// Issues sequential instruction-memory reads starting at RESET_PC. Responses
// (fixed one-cycle latency) are pushed, tagged with pc+4, into a DEPTH-entry
// circular queue. The head is presented to IF/ID directly from storage, so a
// response never bypasses to the output (request -> if_valid_o is 2 cycles).
// A request is only issued when the queue is guaranteed to have room for its
// response. flush_i redirects the PC and discards all fetched state.
//
// Optional feature macro: IF_FETCH_PERF_EN adds the perf_fetch_o and
// perf_stall_o event counters.
//
// DEPTH must be a power of two, >= 2: pointers wrap by natural overflow.
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic [63:0] if_id_o,
    output logic        if_valid_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_pc;        // next fetch address
    logic [31:0]      r_req_pc;    // address of the outstanding read
    logic             r_inflight;  // a read has been issued and not yet returned
    logic             r_kill;      // the outstanding read belongs to a flushed path
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [63:0]      r_mem [DEPTH];  // {pc_plus4, instr}

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             w_valid;
    logic             w_pop;
    logic             w_resp;
    logic             w_push;
    logic [CNT_W-1:0] w_used;
    logic             w_req;

    // The head is valid whenever the queue holds something and we are out of
    // reset; everything downstream keys off this.
    assign w_valid = reset & (r_count != '0);

    // A pop needs a valid head and no stall; a flush discards the head instead.
    assign w_pop = w_valid & ~stall_i & ~flush_i;

    // Only a response to a read we actually issued counts. This also ignores
    // any stray response in the cycle reset is released (inflight is 0 then).
    assign w_resp = imem_valid_i & r_inflight;

    // A live response is written unless it belongs to a killed path or the
    // queue is being flushed this very cycle.
    assign w_push = w_resp & ~r_kill & ~flush_i;

    // Slots committed after this edge: stored entries plus the response that
    // is still owed, minus the entry leaving this cycle. A pop implies
    // r_count >= 1, so this never underflows.
    assign w_used = r_count + CNT_W'(r_inflight) - CNT_W'(w_pop);

    // Request only when the response is certain to find a free slot; this
    // credit rule is what makes a push into a full queue impossible.
    assign w_req = reset & ~flush_i & (w_used < DEPTH_C);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign if_valid_o  = w_valid;
    assign if_id_o     = w_valid ? r_mem[r_rd_ptr] : 64'h0;

    // ------------------------------------------------------------------
    // PC, outstanding-read tracking and kill flag
    // ------------------------------------------------------------------
    // Advance the fetch PC on each issued request, or redirect it on a flush.
    // NOTE: every register below is assigned with <= so all flops sample the
    // same pre-edge values; a blocking = here would let later statements see
    // half-updated state and would not match the synthesized hardware.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (flush_i) begin
            r_pc <= branch_target_i;
            // A read returning during the flush cycle is dropped by the flush
            // itself; only a read still outstanding afterwards needs the kill
            // flag to drop it later. With one-cycle memory latency the read
            // always returns in the flush cycle, so kill normally stays 0.
            r_inflight <= r_inflight & ~imem_valid_i;
            r_kill     <= r_inflight & ~imem_valid_i;
        end else begin
            if (w_req) begin
                r_pc     <= r_pc + 32'd4;  // wraps 32'hFFFF_FFFC -> 0
                r_req_pc <= r_pc;
            end
            r_inflight <= w_req | (r_inflight & ~imem_valid_i);
            if (w_resp && r_kill) begin
                r_kill <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    // Move the tail on push and the head on pop; both may move in one cycle,
    // which leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // Write the response, tagged with its pc+4, at the tail.
    // NOTE: the storage array has no reset on purpose; an entry is only ever
    // read while r_count says it was written, so resetting it would only cost
    // a reset net to every bit without changing behaviour.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_req_pc + 32'd4, imem_data_i};
        end
    end

`ifdef IF_FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Count accepted pushes and cycles where a valid head is held by a stall.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_valid && stall_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch -- self-checking bench for if_fetch.
//
// A one-cycle-latency memory answers every request the DUT issues. A
// transaction-level model (a queue of expected IF/ID words plus the expected
// fetch PC) predicts every output each cycle. Directed steps cover reset,
// start-up latency, stall fill/drain, flush with a read in flight, flush
// beating stall and PC wrap; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk_i = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_valid_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [63:0] if_id_o;
    logic        if_valid_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;
`endif

    if_fetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .reset          (reset),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_valid_i   (imem_valid_i),
        .imem_data_i    (imem_data_i),
`ifdef IF_FETCH_PERF_EN
        .perf_fetch_o   (perf_fetch_o),
        .perf_stall_o   (perf_stall_o),
`endif
        .if_id_o        (if_id_o),
        .if_valid_o     (if_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: what IF/ID should show, in order, and where fetch is.
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_pend = 1'b0;       // a read is owed to the queue next cycle
    logic [31:0] m_pend_addr = 32'h0;
    logic [31:0] m_pushes = 32'h0;
    logic [31:0] m_stalls = 32'h0;

    // Memory environment: remembers the request the DUT issued last cycle.
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input bit rst, input bit stl, input bit fl,
                         input logic [31:0] tgt, input bit inject);
        bit          exp_valid;
        bit          pop;
        bit          exp_req;
        int          used;
        logic [63:0] exp_id;
        bit          nxt_pend;
        logic [31:0] nxt_addr;

        reset           = rst;
        stall_i         = stl;
        flush_i         = fl;
        branch_target_i = tgt;
        imem_valid_i    = mem_pend | inject;
        imem_data_i     = mem_pend ? memword(mem_addr) : $urandom;
        #1;

        exp_valid = rst && (exp_q.size() != 0);
        exp_id    = exp_valid ? exp_q[0] : 64'h0;
        pop       = exp_valid && !stl && !fl;
        used      = exp_q.size() + int'(m_pend) - int'(pop);
        exp_req   = rst && !fl && (used < DEPTH);

        check("if_valid", 64'(if_valid_o), 64'(exp_valid));
        check("if_id", if_id_o, exp_id);
        check("imem_req", 64'(imem_req_o), 64'(exp_req));
        if (exp_req) check("imem_addr", 64'(imem_addr_o), 64'(m_pc));
`ifdef IF_FETCH_PERF_EN
        check("perf_fetch", 64'(perf_fetch_o), 64'(m_pushes));
        check("perf_stall", 64'(perf_stall_o), 64'(m_stalls));
`endif

        nxt_pend = imem_req_o;
        nxt_addr = imem_addr_o;

        if (!rst) begin
            exp_q.delete();
            m_pc     = RESET_PC;
            m_pend   = 1'b0;
            m_pushes = 32'h0;
            m_stalls = 32'h0;
        end else begin
            if (exp_valid && stl) m_stalls++;
            if (fl) begin
                exp_q.delete();
                m_pc   = tgt;
                m_pend = 1'b0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (m_pend) begin
                    exp_q.push_back({m_pend_addr + 32'd4, memword(m_pend_addr)});
                    m_pushes++;
                end
                if (exp_req) begin
                    m_pend      = 1'b1;
                    m_pend_addr = m_pc;
                    m_pc        = m_pc + 32'd4;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end

        @(posedge clk_i);
        mem_pend = nxt_pend;
        mem_addr = nxt_addr;
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);

        // Reset held: nothing requested, nothing presented.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_req", 64'(imem_req_o), 64'h0);
        check("rst_valid", 64'(if_valid_o), 64'h0);

        // Release with a stray response: it must be ignored. First request is
        // RESET_PC, first head {4, mem[0]} two cycles after release.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("second_addr", 64'(imem_addr_o), 64'h4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("first_head_valid", 64'(if_valid_o), 64'h1);
        check("first_head", if_id_o, {32'h4, memword(32'h0)});
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Long stall: queue fills, requests stop, head holds; then drain.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_full_noreq", 64'(imem_req_o), 64'h0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Flush with a read in flight: stale data dropped, refetch at 0x100.
        cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        check("flush_addr", 64'(imem_addr_o), 64'h100);
        check("flush_empty", 64'(if_valid_o), 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_head", if_id_o, {32'h104, memword(32'h100)});
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Flush and stall together on a full queue: flush wins.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0);
        check("flush_stall_valid", 64'(if_valid_o), 64'h0);
        check("flush_stall_id", if_id_o, 64'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // PC wrap: fetch at 0xFFFF_FFFC yields pc_plus4 = 0, next address 0.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_next_addr", 64'(imem_addr_o), 64'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_head", if_id_o, {32'h0, memword(32'hFFFF_FFFC)});
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while a read is in flight, then restart from RESET_PC.
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          r_rst;
            bit          r_stl;
            bit          r_fl;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) != 0);
            r_stl = ($urandom_range(0, 2) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
            cycle(r_rst, r_stl, r_fl, r_tgt, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
